conv_channel_err: RTL and testbench

Channel error injector between the convolutional encoder and the Viterbi decoder. It takes each 2-bit code symbol with its valid strobe and forwards it one cycle later, with selected bits inverted according to a programmable error mode (bypass, periodic, random LFSR, burst). It also counts the bits it has inverted, so the Viterbi decoder's correction capability can be exercised and measured on the loopback path.

---
 rtl/chan_err_pkg.sv | 23 ++
 rtl/lfsr16.sv | 26 ++
 rtl/conv_channel_err.sv | 172 +++++++++++++++++
 tb/tb_conv_channel_err.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
package chan_err_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_RANDOM   = 2'd2,
        MODE_BURST    = 2'd3
    } mode_t;

    typedef enum logic {
        S_GAP   = 1'b0,
        S_BURST = 1'b1
    } burst_state_t;

    // Taps of x^16+x^14+x^13+x^11+1 for a left-shifting Fibonacci register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[1]} + {1'b0, m[0]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0; advances only when enabled.
module lfsr16
    import chan_err_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // State register; the seed must be nonzero or the sequence locks up
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {r_state[14:0], ^(r_state & LFSR_TAPS)};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/conv_channel_err.sv
// Channel error injector: forwards 2-bit code symbols one cycle later with
// mode-dependent bit inversions and a saturating count of inverted bits.
module conv_channel_err
    import chan_err_pkg::*;
#(
    parameter int                   SIZE_OUT  = 2,
    parameter int                   SIZE_CNT  = 16,
    parameter int                   SIZE_LFSR = 16,
    parameter logic [SIZE_LFSR-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [SIZE_OUT-1:0] i_data,
    input  logic [1:0]          i_mode,
    input  logic [7:0]          i_period,
    input  logic [3:0]          i_burst_len,
    input  logic [7:0]          i_threshold,
    input  logic                i_clear,
    output logic [SIZE_OUT-1:0] o_data,
    output logic                o_valid,
    output logic                o_err_flag,
    output logic [SIZE_CNT-1:0] o_err_cnt
);

    mode_t                r_mode;
    burst_state_t         r_state;
    logic [7:0]           r_sym_cnt;
    logic [3:0]           r_burst_cnt;
    logic [SIZE_OUT-1:0]  r_data;
    logic                 r_valid;
    logic                 r_err_flag;
    logic [SIZE_CNT-1:0]  r_err_cnt;

    mode_t                w_mode;
    logic                 w_mode_chg;
    burst_state_t         w_state_base;
    burst_state_t         w_state_nxt;
    logic [7:0]           w_sym_base;
    logic [7:0]           w_sym_nxt;
    logic [3:0]           w_burst_base;
    logic [3:0]           w_burst_nxt;
    logic [1:0]           w_mask;
    logic                 w_lfsr_en;
    logic [SIZE_LFSR-1:0] w_lfsr;
    logic                 w_unused_lfsr;
    logic [SIZE_CNT:0]    w_cnt_sum;
    logic [SIZE_CNT-1:0]  w_cnt_nxt;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_lfsr_en),
        .o_state (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[SIZE_LFSR-1:9];

    // A mode change restarts the pattern; a symbol in that same cycle sees the cleared state
    assign w_mode       = mode_t'(i_mode);
    assign w_mode_chg   = (w_mode != r_mode);
    assign w_sym_base   = w_mode_chg ? 8'd0 : r_sym_cnt;
    assign w_burst_base = w_mode_chg ? 4'd0 : r_burst_cnt;
    assign w_state_base = w_mode_chg ? S_GAP : r_state;

    // Error mask and next pattern state for the accepted symbol
    always_comb begin
        w_mask      = 2'b00;
        w_lfsr_en   = 1'b0;
        w_sym_nxt   = w_sym_base;
        w_burst_nxt = w_burst_base;
        w_state_nxt = w_state_base;
        if (i_valid) begin
            case (w_mode)
                MODE_BYPASS: begin
                    w_mask = 2'b00;
                end
                MODE_PERIODIC: begin
                    if (({1'b0, w_sym_base} + 9'd1) == {1'b0, i_period}) begin
                        w_mask    = 2'b01;
                        w_sym_nxt = 8'd0;
                    end else begin
                        w_sym_nxt = w_sym_base + 8'd1;
                    end
                end
                MODE_RANDOM: begin
                    w_lfsr_en = 1'b1;
                    if (w_lfsr[7:0] < i_threshold) begin
                        w_mask = w_lfsr[8] ? 2'b10 : 2'b01;
                    end else begin
                        w_mask = 2'b00;
                    end
                end
                MODE_BURST: begin
                    case (w_state_base)
                        S_GAP: begin
                            if ((i_period != 8'd0) && (i_burst_len != 4'd0) &&
                                (({1'b0, w_sym_base} + 9'd1) == {1'b0, i_period})) begin
                                w_sym_nxt   = 8'd0;
                                w_state_nxt = S_BURST;
                            end else begin
                                w_sym_nxt = w_sym_base + 8'd1;
                            end
                        end
                        S_BURST: begin
                            w_mask = 2'b11;
                            if (({1'b0, w_burst_base} + 5'd1) >= {1'b0, i_burst_len}) begin
                                w_burst_nxt = 4'd0;
                                w_state_nxt = S_GAP;
                            end else begin
                                w_burst_nxt = w_burst_base + 4'd1;
                            end
                        end
                        default: begin
                            w_state_nxt = S_GAP;
                        end
                    endcase
                end
                default: begin
                    w_mask = 2'b00;
                end
            endcase
        end else begin
            w_mask = 2'b00;
        end
    end

    assign w_cnt_sum = {1'b0, r_err_cnt} + {{(SIZE_CNT-1){1'b0}}, popcount2(w_mask)};
    assign w_cnt_nxt = w_cnt_sum[SIZE_CNT] ? {SIZE_CNT{1'b1}} : w_cnt_sum[SIZE_CNT-1:0];

    // Pattern state and mode tracking
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode      <= MODE_BYPASS;
            r_state     <= S_GAP;
            r_sym_cnt   <= 8'd0;
            r_burst_cnt <= 4'd0;
        end else begin
            r_mode      <= w_mode;
            r_state     <= w_state_nxt;
            r_sym_cnt   <= w_sym_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Output stage and saturating error counter; clear wins over the increment
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data     <= {SIZE_OUT{1'b0}};
            r_valid    <= 1'b0;
            r_err_flag <= 1'b0;
            r_err_cnt  <= {SIZE_CNT{1'b0}};
        end else begin
            r_valid    <= i_valid;
            r_err_flag <= i_valid & (|w_mask);
            if (i_valid) begin
                r_data <= i_data ^ w_mask;
            end
            if (i_clear) begin
                r_err_cnt <= {SIZE_CNT{1'b0}};
            end else if (i_valid) begin
                r_err_cnt <= w_cnt_nxt;
            end
        end
    end

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_err_flag = r_err_flag;
    assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_conv_channel_err.sv
// Randomized scoreboard bench for conv_channel_err against a pattern-level reference model.
module tb_conv_channel_err;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [1:0]  i_data;
    logic [1:0]  i_mode;
    logic [7:0]  i_period;
    logic [3:0]  i_burst_len;
    logic [7:0]  i_threshold;
    logic        i_clear;
    logic [1:0]  o_data;
    logic        o_valid;
    logic        o_err_flag;
    logic [15:0] o_err_cnt;

    typedef struct {
        logic [1:0]  data;
        logic        flag;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // reference model state
    logic [15:0] m_lfsr;
    int          m_n;
    int          m_cnt;
    logic [1:0]  m_prev_mode;

    conv_channel_err dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_mode      (i_mode),
        .i_period    (i_period),
        .i_burst_len (i_burst_len),
        .i_threshold (i_threshold),
        .i_clear     (i_clear),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_err_flag  (o_err_flag),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic model_reset();
        m_lfsr      = 16'hACE1;
        m_n         = 0;
        m_cnt       = 0;
        m_prev_mode = 2'd0;
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [1:0] md, input logic clr);
        logic [1:0] mask;
        int idx;
        exp_t e;
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        i_mode  = md;
        i_clear = clr;
        if (md != m_prev_mode) m_n = 0;
        m_prev_mode = md;
        if (clr) m_cnt = 0;
        if (v) begin
            mask = 2'b00;
            case (md)
                2'd1: begin
                    m_n++;
                    if (i_period != 8'd0 && (m_n % int'(i_period)) == 0) mask = 2'b01;
                end
                2'd2: begin
                    if (m_lfsr[7:0] < i_threshold) mask = m_lfsr[8] ? 2'b10 : 2'b01;
                    m_lfsr = lfsr_step(m_lfsr);
                end
                2'd3: begin
                    if (i_period != 8'd0 && i_burst_len != 4'd0) begin
                        idx = m_n % (int'(i_period) + int'(i_burst_len));
                        m_n++;
                        if (idx >= int'(i_period)) mask = 2'b11;
                    end
                end
                default: mask = 2'b00;
            endcase
            if (!clr) begin
                m_cnt = m_cnt + int'(mask[0]) + int'(mask[1]);
                if (m_cnt > 65535) m_cnt = 65535;
            end
            e.data = d ^ mask;
            e.flag = |mask;
            e.cnt  = 16'(m_cnt);
            exp_q.push_back(e);
        end
    endtask

    // idle cycle in bypass; config may be changed right after it
    task automatic idle(input logic clr);
        drive(1'b0, 2'b00, 2'd0, clr);
    endtask

    // monitor: compare each presented symbol with the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", {30'd0, o_data}, {30'd0, e.data});
                    chk("err_flag", {31'd0, o_err_flag}, {31'd0, e.flag});
                    chk("err_cnt", {16'd0, o_err_cnt}, {16'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nsym;
        logic [1:0] md;
        i_rst = 1'b1; i_valid = 1'b0; i_data = 2'b00; i_mode = 2'd0;
        i_period = 8'd0; i_burst_len = 4'd0; i_threshold = 8'd0; i_clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_data", {30'd0, o_data}, 32'd0);
        chk("rst_flag", {31'd0, o_err_flag}, 32'd0);
        chk("rst_cnt", {16'd0, o_err_cnt}, 32'd0);
        @(negedge clk);
        i_rst = 1'b0;

        // bypass
        for (int i = 0; i < 8; i++) drive(1'b1, 2'(i), 2'd0, 1'b0);
        idle(1'b0);
        #1 chk("bypass_cnt", {16'd0, o_err_cnt}, 32'd0);

        // periodic, period 4
        idle(1'b1);
        i_period = 8'd4;
        for (int i = 0; i < 12; i++) drive(1'b1, 2'b00, 2'd1, 1'b0);
        idle(1'b0);
        #1 chk("periodic_cnt", {16'd0, o_err_cnt}, 32'd3);

        // burst, gap 3 length 2
        idle(1'b1);
        i_period = 8'd3; i_burst_len = 4'd2;
        for (int i = 0; i < 10; i++) drive(1'b1, 2'b10, 2'd3, 1'b0);
        idle(1'b0);
        #1 chk("burst_cnt", {16'd0, o_err_cnt}, 32'd8);

        // random, threshold 0 then 255
        idle(1'b0);
        i_threshold = 8'd0;
        for (int i = 0; i < 32; i++) drive(1'b1, 2'($urandom), 2'd2, 1'b0);
        idle(1'b0);
        i_threshold = 8'd255;
        for (int i = 0; i < 256; i++) drive(1'b1, 2'($urandom), 2'd2, 1'b0);

        // randomized segments with gaps, occasional clears, mode changes
        for (int s = 0; s < 16; s++) begin
            idle(1'b0);
            md          = 2'($urandom);
            i_period    = ($urandom % 6 == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            i_burst_len = 4'($urandom_range(0, 4));
            i_threshold = 8'($urandom);
            nsym        = $urandom_range(10, 40);
            for (int i = 0; i < nsym; i++)
                drive(($urandom % 4) != 0, 2'($urandom), md, ($urandom % 32) == 0);
        end

        // saturation: continuous bursts
        idle(1'b0);
        i_period = 8'd1; i_burst_len = 4'd15;
        for (int i = 0; i < 35200; i++) drive(1'b1, 2'b00, 2'd3, 1'b0);
        idle(1'b0);
        #1 chk("sat_hold", {16'd0, o_err_cnt}, 32'h0000FFFF);

        // clear in the same cycle as an error
        idle(1'b0);
        i_period = 8'd1;
        drive(1'b1, 2'b00, 2'd1, 1'b0);
        drive(1'b1, 2'b00, 2'd1, 1'b1);
        idle(1'b0);
        #1 chk("clear_with_err", {16'd0, o_err_cnt}, 32'd0);

        // reset in the middle of a burst drops the in-flight symbol
        idle(1'b0);
        i_period = 8'd3; i_burst_len = 4'd2;
        for (int i = 0; i < 4; i++) drive(1'b1, 2'b10, 2'd3, 1'b0);
        @(negedge clk);
        i_valid = 1'b1; i_data = 2'b10; i_mode = 2'd3;
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_data", {30'd0, o_data}, 32'd0);
        chk("midrst_flag", {31'd0, o_err_flag}, 32'd0);
        chk("midrst_cnt", {16'd0, o_err_cnt}, 32'd0);
        i_valid = 1'b0; i_mode = 2'd0;
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 2'b10, 2'd3, 1'b0);
        idle(1'b0);
        #1 chk("postrst_cnt", {16'd0, o_err_cnt}, 32'd8);

        repeat (4) idle(1'b0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
